spis_protocol_monitor: RTL and testbench

- Synthesizable, parametrised protocol monitor that sits passively beside an SPI slave FSM and observes its serial side (ss_n, MOSI, MISO) and its parallel side (rx/tx handshakes).
- Checks reset values, sready timing, rx frame timing and content, and tx serialisation order.
- Reports violations as sticky flags, single-cycle pulses and a saturating error counter, for use in simulation, emulation and on-chip debug.
- Generalises the fixed 10-bit/8-bit slave checks to configurable frame widths and latencies.

---
 rtl/spis_protocol_monitor_if.sv | 31 +++
 rtl/spis_protocol_monitor.sv | 227 ++++++++++++++++++++++
 tb/tb_spis_protocol_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/spis_protocol_monitor_if.sv
// Observation bundle between an SPI slave FSM and its passive protocol monitor.
// Latency: none, wires only.
// Backpressure: none; the monitor only listens, it never drives these signals.
//
// Signals: ss_n/mosi/miso are the serial side; sready, rx_valid/rx_data,
// tx_valid/tx_data and valid_miso are the slave's parallel side.
// master modport drives the bundle (the slave or a bench); slave modport observes it.
interface spis_protocol_monitor_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
);
    logic            ss_n;
    logic            mosi;
    logic            miso;
    logic            sready;
    logic            rx_valid;
    logic [RX_W-1:0] rx_data;
    logic            tx_valid;
    logic [TX_W-1:0] tx_data;
    logic            valid_miso;

    modport master (
        output ss_n, mosi, miso, sready, rx_valid, rx_data,
               tx_valid, tx_data, valid_miso
    );

    modport slave (
        input  ss_n, mosi, miso, sready, rx_valid, rx_data,
               tx_valid, tx_data, valid_miso
    );
endinterface

// File: rtl/spis_protocol_monitor.sv
// Passive SPI-slave protocol checker: reset values, sready timing, rx frame timing/content, tx serialisation.
// Latency: a violation sampled at edge N shows in err_flags/err_pulse/err_cnt after edge N (visible in cycle N+1).
// Backpressure: none; purely observes, never stalls or drives the slave.
//
// Ports: clk, rst_n (async, active low); mon = observed slave signals (interface, slave modport);
// clr_err = synchronous clear of err_flags/err_cnt; err_flags[5:0] sticky
// {abort, miso, rx_data, rx_timing, sready, reset}; err_pulse = one cycle per violating cycle;
// err_cnt = saturating violation count; frame_cnt = wrapping count of completed rx frames;
// busy = frame FSM not idle.
// Optional: define SPIS_MON_TXCHK_EN to build the tx latch and MISO/valid_miso checks;
// without it err_flags[4] is tied 0 and the tx signals are only seen by the post-reset check.
module spis_protocol_monitor #(
    parameter int RX_W     = 10,
    parameter int TX_W     = 8,
    parameter int RX_LAT   = 2,
    parameter int SRDY_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spis_protocol_monitor_if.slave mon,
    input  logic                   clr_err,
    output logic [5:0]             err_flags,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       frame_cnt,
    output logic                   busy
);

    // ofs counts edges since the detected ss_n fall: at edge T+k, ofs == k.
    localparam int RX_EXP  = RX_W + RX_LAT;
    localparam int OFS_MAX = ((RX_EXP > SRDY_LAT) ? RX_EXP : SRDY_LAT) + 1;
    localparam int OFS_W   = $clog2(OFS_MAX + 1);

    localparam logic [OFS_W-1:0] O_MAX  = OFS_W'(OFS_MAX);
    localparam logic [OFS_W-1:0] O_RXW  = OFS_W'(RX_W);
    localparam logic [OFS_W-1:0] O_EXP  = OFS_W'(RX_EXP);
    localparam logic [OFS_W-1:0] O_SRLO = OFS_W'(SRDY_LAT);
    localparam logic [OFS_W-1:0] O_SRHI = OFS_W'(SRDY_LAT - 1);

    typedef enum logic [2:0] {IDLE, SEL, CAPT, WAIT_RX, DONE} state_t;

    state_t            state, state_nxt;
    logic [OFS_W-1:0]  ofs, ofs_nxt;
    logic [RX_W-1:0]   cap, cap_nxt;
    logic              ss_prev;
    logic              rx_prev;
    logic              chk_pend;
    logic              frame_inc;
    logic [5:0]        viol;
    logic              tx_viol;
    logic [5:0]        viol_all;
    logic              any_viol;

    logic ss_fall, ss_rise, rx_rise, active;

    assign ss_fall = ~mon.ss_n &  ss_prev;
    assign ss_rise =  mon.ss_n & ~ss_prev;
    assign rx_rise =  mon.rx_valid & ~rx_prev;
    assign active  = (state == SEL) || (state == CAPT) || (state == WAIT_RX);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ofs      <= '0;
            cap      <= '0;
            ss_prev  <= 1'b1;
            rx_prev  <= 1'b0;
            chk_pend <= 1'b1;
        end else begin
            state    <= state_nxt;
            ofs      <= ofs_nxt;
            cap      <= cap_nxt;
            ss_prev  <= mon.ss_n;
            rx_prev  <= mon.rx_valid;
            chk_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        ofs_nxt   = ofs;
        cap_nxt   = cap;
        frame_inc = 1'b0;
        viol      = '0;

        // One-shot check of the slave's reset outputs on the first edge out of reset.
        if (chk_pend && (mon.rx_valid || (mon.rx_data != '0) || !mon.sready ||
                         mon.valid_miso || mon.miso))
            viol[0] = 1'b1;

        if (state == IDLE) begin
            if (ss_fall) begin
                state_nxt = SEL;
                ofs_nxt   = OFS_W'(1);
                cap_nxt   = '0;
                // With a latency of 1 the "still high" sample falls on the fall edge itself.
                if ((SRDY_LAT == 1) && !mon.sready)
                    viol[1] = 1'b1;
            end
            if (rx_rise)
                viol[2] = 1'b1;
        end else begin
            if (ofs != O_MAX)
                ofs_nxt = ofs + OFS_W'(1);

            if ((SRDY_LAT > 1) && (ofs == O_SRHI) && !mon.sready)
                viol[1] = 1'b1;
            if ((ofs == O_SRLO) && mon.sready)
                viol[1] = 1'b1;

            // MOSI is taken MSB first at T+1..T+RX_W; SEL covers the first bit.
            if (active && (ofs <= O_RXW))
                cap_nxt = {cap[RX_W-2:0], mon.mosi};

            case (state)
                SEL:     state_nxt = CAPT;
                CAPT:    if (ofs == O_RXW) state_nxt = WAIT_RX;
                WAIT_RX: state_nxt = WAIT_RX;
                DONE:    if (mon.ss_n) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase

            // The comparison uses cap_nxt so a zero RX_LAT still sees the final bit.
            if (active && (ofs == O_EXP)) begin
                state_nxt = DONE;
                if (mon.rx_valid) begin
                    frame_inc = 1'b1;
                    if (mon.rx_data != cap_nxt)
                        viol[3] = 1'b1;
                end else begin
                    viol[2] = 1'b1;
                end
            end else if (rx_rise) begin
                viol[2] = 1'b1;
            end

            // Abort drops the frame: no rx verdict, no frame count.
            if (active && ss_rise) begin
                state_nxt = IDLE;
                viol[5]   = 1'b1;
                viol[3]   = 1'b0;
                viol[2]   = 1'b0;
                frame_inc = 1'b0;
            end
        end
    end

`ifdef SPIS_MON_TXCHK_EN
    localparam int TK_W = (TX_W > 1) ? $clog2(TX_W) : 1;

    logic            tx_prev;
    logic            vm_prev;
    logic            tx_act;
    logic [TK_W-1:0] tx_k;
    logic [TX_W-1:0] tx_sh;
    logic            tx_rise;

    assign tx_rise = mon.tx_valid & ~tx_prev;

    always_comb begin
        tx_viol = 1'b0;
        if (tx_act) begin
            // valid_miso has to rise together with the first serialised bit.
            if ((tx_k == '0) && !(mon.valid_miso && !vm_prev))
                tx_viol = 1'b1;
            if (mon.miso != tx_sh[TX_W-1])
                tx_viol = 1'b1;
            if (tx_rise)
                tx_viol = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_prev <= 1'b0;
            vm_prev <= 1'b0;
            tx_act  <= 1'b0;
            tx_k    <= '0;
            tx_sh   <= '0;
        end else begin
            tx_prev <= mon.tx_valid;
            vm_prev <= mon.valid_miso;
            if (tx_rise) begin
                tx_act <= 1'b1;
                tx_k   <= '0;
                tx_sh  <= mon.tx_data;
            end else if (tx_act) begin
                tx_sh <= tx_sh << 1;
                tx_k  <= tx_k + TK_W'(1);
                if (tx_k == TK_W'(TX_W - 1))
                    tx_act <= 1'b0;
            end
        end
    end
`else
    logic unused_tx;
    assign unused_tx = ^{mon.tx_valid, mon.tx_data};
    assign tx_viol   = 1'b0;
`endif

    assign viol_all = {viol[5], tx_viol, viol[3:0]};
    assign any_viol = |viol_all;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            err_pulse <= any_viol;
            frame_cnt <= frame_cnt + CNT_W'(frame_inc);
            // A violation coinciding with clr_err survives the clear.
            if (clr_err) begin
                err_flags <= viol_all;
                err_cnt   <= CNT_W'(any_viol);
            end else begin
                err_flags <= err_flags | viol_all;
                if (any_viol && (err_cnt != {CNT_W{1'b1}}))
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spis_protocol_monitor.sv
module tb_spis_protocol_monitor;
    localparam int RX_W     = 10;
    localparam int TX_W     = 8;
    localparam int RX_LAT   = 2;
    localparam int SRDY_LAT = 2;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_err = 1'b0;
    logic [5:0]       err_flags;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy;

    int tests = 0;
    int fails = 0;

    spis_protocol_monitor_if #(.RX_W(RX_W), .TX_W(TX_W)) bus ();

    spis_protocol_monitor #(
        .RX_W(RX_W), .TX_W(TX_W), .RX_LAT(RX_LAT), .SRDY_LAT(SRDY_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mon       (bus),
        .clr_err   (clr_err),
        .err_flags (err_flags),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .frame_cnt (frame_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ss_n       = 1'b1;
        bus.mosi       = 1'b0;
        bus.miso       = 1'b0;
        bus.sready     = 1'b1;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = '0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.valid_miso = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        clr_err = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // k = offset from the ss_n fall edge T; inputs set before the edge T+k.
    task automatic frame(input logic [RX_W-1:0] bits, input int rx_at,
                         input logic [RX_W-1:0] rx_dat, input int abort_at, input bit srdy_ok);
        for (int k = 0; k <= 14; k++) begin
            bus.ss_n     = (abort_at > 0) && (k >= abort_at);
            bus.mosi     = (k >= 1 && k <= RX_W) ? bits[RX_W-k] : 1'b0;
            bus.sready   = (srdy_ok && k >= SRDY_LAT) ? 1'b0 : 1'b1;
            bus.rx_valid = (k == rx_at);
            bus.rx_data  = (k == rx_at) ? rx_dat : '0;
            tick();
            if (abort_at == 0 && k == 3)
                chk("busy_mid_frame", busy, 1);
            if (abort_at > 0 && k == abort_at)
                chk("busy_after_abort", busy, 0);
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic tx_seq(input logic [TX_W-1:0] w, input int flip);
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        tick();
        bus.tx_valid = 1'b0;
        for (int k = 0; k < TX_W; k++) begin
            bus.valid_miso = 1'b1;
            bus.miso       = w[TX_W-1-k] ^ (k == flip);
            tick();
        end
        bus.valid_miso = 1'b0;
        bus.miso       = 1'b0;
        tick();
    endtask

    initial begin
        // Outputs while reset is held.
        idle_inputs();
        #2;
        chk("rst_flags", err_flags, 0);
        chk("rst_pulse", err_pulse, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_ok_flags", err_flags, 0);
        chk("postrst_ok_cnt", err_cnt, 0);

        // Non-zero rx_data out of reset.
        do_reset();
        bus.rx_data = 10'h001;
        tick();
        bus.rx_data = '0;
        chk("postrst_bad_flags", err_flags, 6'h01);
        chk("postrst_bad_pulse", err_pulse, 1);
        chk("postrst_bad_cnt", err_cnt, 1);
        tick();
        chk("pulse_one_cycle", err_pulse, 0);
        chk("flag_sticky", err_flags, 6'h01);
        do_clr();
        chk("clr_flags", err_flags, 0);
        chk("clr_cnt", err_cnt, 0);

        // Compliant frame.
        frame(10'b1100110101, 12, 10'h335, 0, 1'b1);
        chk("good_frame_flags", err_flags, 0);
        chk("good_frame_cnt", frame_cnt, 1);
        chk("good_frame_err_cnt", err_cnt, 0);

        // rx_valid one cycle late.
        frame(10'b1100110101, 13, 10'h335, 0, 1'b1);
        chk("late_rx_flags", err_flags, 6'h04);
        chk("late_rx_frame_cnt", frame_cnt, 1);
        do_clr();

        // Wrong rx word.
        frame(10'b1100110101, 12, 10'h334, 0, 1'b1);
        chk("bad_data_flags", err_flags, 6'h08);
        chk("bad_data_frame_cnt", frame_cnt, 2);
        do_clr();

        // TX serialisation.
        tx_seq(8'hA5, 99);
        chk("tx_good_flags", err_flags, 0);
        tx_seq(8'hA5, 3);
`ifdef SPIS_MON_TXCHK_EN
        chk("tx_flip_flags", err_flags, 6'h10);
`else
        chk("tx_flip_flags", err_flags, 0);
`endif
        do_clr();

        // Abort mid-frame, then a clean frame.
        frame(10'b1100110101, 99, '0, 5, 1'b1);
        chk("abort_flags", err_flags, 6'h20);
        chk("abort_frame_cnt", frame_cnt, 2);
        do_clr();
        frame(10'b1100110101, 12, 10'h335, 0, 1'b1);
        chk("after_abort_flags", err_flags, 0);
        chk("after_abort_frame_cnt", frame_cnt, 3);

        // sready never drops.
        frame(10'b1100110101, 12, 10'h335, 0, 1'b0);
        chk("sready_flags", err_flags, 6'h02);
        chk("sready_frame_cnt", frame_cnt, 4);
        do_clr();

        // Reset in the middle of a frame.
        bus.ss_n = 1'b0;
        tick();
        tick();
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        bus.sready = 1'b0;
        tick();
        bus.sready = 1'b1;
        chk("midrst_rearm_flags", err_flags, 6'h01);
        do_clr();

        // Saturation: 300 rx_valid rises while idle.
        for (int i = 0; i < 300; i++) begin
            bus.rx_valid = 1'b1;
            tick();
            bus.rx_valid = 1'b0;
            tick();
        end
        chk("sat_err_cnt", err_cnt, 255);
        chk("sat_flags", err_flags, 6'h04);
        clr_err = 1'b1;
        bus.rx_valid = 1'b1;
        tick();
        clr_err = 1'b0;
        bus.rx_valid = 1'b0;
        chk("clr_viol_cnt", err_cnt, 1);
        chk("clr_viol_flags", err_flags, 6'h04);
        chk("clr_viol_pulse", err_pulse, 1);
        tick();
        do_clr();
        chk("final_clr_cnt", err_cnt, 0);
        chk("final_clr_flags", err_flags, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
